// File: rtl/alu_unit_pkg.sv
// rtl/alu_unit_pkg.sv - shared opcode enum, width defaults and boolean constants
package alu_unit_pkg;

  localparam int DATA_W_DEF    = 32;
  localparam int ROB_POS_W_DEF = 5;
  localparam int OPENUM_W      = 6;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  // Loads and stores share the encoding space but are executed by the LSB.
  typedef enum logic [OPENUM_W-1:0] {
    OP_NOP   = 6'd0,
    OP_LUI   = 6'd1,
    OP_AUIPC = 6'd2,
    OP_JAL   = 6'd3,
    OP_JALR  = 6'd4,
    OP_BEQ   = 6'd5,
    OP_BNE   = 6'd6,
    OP_BLT   = 6'd7,
    OP_BGE   = 6'd8,
    OP_BLTU  = 6'd9,
    OP_BGEU  = 6'd10,
    OP_LB    = 6'd11,
    OP_LH    = 6'd12,
    OP_LW    = 6'd13,
    OP_LBU   = 6'd14,
    OP_LHU   = 6'd15,
    OP_SB    = 6'd16,
    OP_SH    = 6'd17,
    OP_SW    = 6'd18,
    OP_ADDI  = 6'd19,
    OP_SLTI  = 6'd20,
    OP_SLTIU = 6'd21,
    OP_XORI  = 6'd22,
    OP_ORI   = 6'd23,
    OP_ANDI  = 6'd24,
    OP_SLLI  = 6'd25,
    OP_SRLI  = 6'd26,
    OP_SRAI  = 6'd27,
    OP_ADD   = 6'd28,
    OP_SUB   = 6'd29,
    OP_SLL   = 6'd30,
    OP_SLT   = 6'd31,
    OP_SLTU  = 6'd32,
    OP_XOR   = 6'd33,
    OP_SRL   = 6'd34,
    OP_SRA   = 6'd35,
    OP_OR    = 6'd36,
    OP_AND   = 6'd37
  } openum_t;

  function automatic logic is_cond_branch(input logic [OPENUM_W-1:0] op);
    case (op)
      OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: return TRUE;
      default: return FALSE;
    endcase
  endfunction

endpackage

// File: rtl/alu_calc.sv
// rtl/alu_calc.sv - combinational RV32I compute of {val, jump, target}
module alu_calc
  import alu_unit_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [OPENUM_W-1:0] openum,
  input  logic [DATA_W-1:0]   rs1_val,
  input  logic [DATA_W-1:0]   rs2_val,
  input  logic [DATA_W-1:0]   imm,
  input  logic [DATA_W-1:0]   pc,
  output logic [DATA_W-1:0]   val,
  output logic                jump,
  output logic [DATA_W-1:0]   target
);

  logic [DATA_W-1:0] pc_imm;
  logic [DATA_W-1:0] pc_next;
  logic [DATA_W-1:0] rs1_imm;
  logic [4:0]        shamt_r;
  logic [4:0]        shamt_i;
  logic              lt_s_r;
  logic              lt_u_r;
  logic              lt_s_i;
  logic              lt_u_i;

  assign pc_imm  = pc + imm;
  assign pc_next = pc + DATA_W'(4);
  assign rs1_imm = rs1_val + imm;
  assign shamt_r = rs2_val[4:0];
  assign shamt_i = imm[4:0];
  assign lt_s_r  = $signed(rs1_val) < $signed(rs2_val);
  assign lt_u_r  = rs1_val < rs2_val;
  assign lt_s_i  = $signed(rs1_val) < $signed(imm);
  assign lt_u_i  = rs1_val < imm;

  always_comb begin
    val    = '0;
    jump   = FALSE;
    target = '0;
    case (openum)
      OP_LUI:   val = imm;
      OP_AUIPC: val = pc_imm;
      OP_JAL: begin
        val    = pc_next;
        jump   = TRUE;
        target = pc_imm;
      end
      OP_JALR: begin
        val    = pc_next;
        jump   = TRUE;
        target = {rs1_imm[DATA_W-1:1], 1'b0};
      end
      OP_BEQ:  begin target = pc_imm; jump = (rs1_val == rs2_val); end
      OP_BNE:  begin target = pc_imm; jump = (rs1_val != rs2_val); end
      OP_BLT:  begin target = pc_imm; jump = lt_s_r;  end
      OP_BGE:  begin target = pc_imm; jump = !lt_s_r; end
      OP_BLTU: begin target = pc_imm; jump = lt_u_r;  end
      OP_BGEU: begin target = pc_imm; jump = !lt_u_r; end
      OP_ADDI:  val = rs1_imm;
      OP_SLTI:  val = DATA_W'(lt_s_i);
      OP_SLTIU: val = DATA_W'(lt_u_i);
      OP_XORI:  val = rs1_val ^ imm;
      OP_ORI:   val = rs1_val | imm;
      OP_ANDI:  val = rs1_val & imm;
      OP_SLLI:  val = rs1_val << shamt_i;
      OP_SRLI:  val = rs1_val >> shamt_i;
      OP_SRAI:  val = DATA_W'($signed(rs1_val) >>> shamt_i);
      OP_ADD:   val = rs1_val + rs2_val;
      OP_SUB:   val = rs1_val - rs2_val;
      OP_SLL:   val = rs1_val << shamt_r;
      OP_SLT:   val = DATA_W'(lt_s_r);
      OP_SLTU:  val = DATA_W'(lt_u_r);
      OP_XOR:   val = rs1_val ^ rs2_val;
      OP_SRL:   val = rs1_val >> shamt_r;
      OP_SRA:   val = DATA_W'($signed(rs1_val) >>> shamt_r);
      OP_OR:    val = rs1_val | rs2_val;
      OP_AND:   val = rs1_val & rs2_val;
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_unit.sv
// rtl/alu_unit.sv - registered ALU result broadcast with flush/stall handling
// Optional branch statistics counters are built when ALU_STAT_EN is defined.
module alu_unit
  import alu_unit_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ROB_POS_W = ROB_POS_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic                 clr,
  input  logic                 in_enable,
  input  logic [OPENUM_W-1:0]  in_openum,
  input  logic [ROB_POS_W-1:0] in_rob_pos,
  input  logic [DATA_W-1:0]    in_rs1_val,
  input  logic [DATA_W-1:0]    in_rs2_val,
  input  logic [DATA_W-1:0]    in_imm,
  input  logic [DATA_W-1:0]    in_pc,
  output logic                 out_ready,
  output logic [ROB_POS_W-1:0] out_rob_pos,
  output logic [DATA_W-1:0]    out_val,
  output logic                 out_jump,
  output logic [DATA_W-1:0]    out_target,
  output logic [31:0]          stat_branch_cnt,
  output logic [31:0]          stat_taken_cnt
);

  logic [DATA_W-1:0] calc_val;
  logic              calc_jump;
  logic [DATA_W-1:0] calc_target;

  alu_calc #(
    .DATA_W(DATA_W)
  ) u_calc (
    .openum (in_openum),
    .rs1_val(in_rs1_val),
    .rs2_val(in_rs2_val),
    .imm    (in_imm),
    .pc     (in_pc),
    .val    (calc_val),
    .jump   (calc_jump),
    .target (calc_target)
  );

  // Data registers keep their last value when idle; only ready/jump are qualified.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_ready   <= FALSE;
      out_rob_pos <= '0;
      out_val     <= '0;
      out_jump    <= FALSE;
      out_target  <= '0;
    end else if (rdy) begin
      if (clr || !in_enable) begin
        out_ready <= FALSE;
        out_jump  <= FALSE;
      end else begin
        out_ready   <= TRUE;
        out_rob_pos <= in_rob_pos;
        out_val     <= calc_val;
        out_jump    <= calc_jump;
        out_target  <= calc_target;
      end
    end
  end

`ifdef ALU_STAT_EN
  logic [31:0] branch_cnt;
  logic [31:0] taken_cnt;
  logic        count_en;

  assign count_en = rdy && !clr && in_enable && is_cond_branch(in_openum);

  // Saturating counters; flushes do not clear them.
  always_ff @(posedge clk) begin
    if (rst) begin
      branch_cnt <= '0;
      taken_cnt  <= '0;
    end else if (count_en) begin
      if (branch_cnt != '1) branch_cnt <= branch_cnt + 32'd1;
      if (calc_jump && taken_cnt != '1) taken_cnt <= taken_cnt + 32'd1;
    end
  end

  assign stat_branch_cnt = branch_cnt;
  assign stat_taken_cnt  = taken_cnt;
`else
  assign stat_branch_cnt = '0;
  assign stat_taken_cnt  = '0;
`endif

endmodule

// File: tb/tb_alu_unit.sv
// tb/tb_alu_unit.sv - table-driven self-checking bench for alu_unit
module tb_alu_unit;
  import alu_unit_pkg::*;

  typedef struct {
    logic [OPENUM_W-1:0] op;
    logic [31:0]         rs1;
    logic [31:0]         rs2;
    logic [31:0]         imm;
    logic [31:0]         pc;
    logic [31:0]         val;
    logic                jump;
    logic [31:0]         target;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, rdy, clr, in_enable;
  logic [5:0]  in_openum;
  logic [4:0]  in_rob_pos;
  logic [31:0] in_rs1_val, in_rs2_val, in_imm, in_pc;
  logic        out_ready, out_jump;
  logic [4:0]  out_rob_pos;
  logic [31:0] out_val, out_target, stat_branch_cnt, stat_taken_cnt;

  int total = 0;
  int bad   = 0;
  vec_t vecs[$];
  logic [31:0] exp_br, exp_tk;

  alu_unit dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clr(clr),
    .in_enable(in_enable), .in_openum(in_openum), .in_rob_pos(in_rob_pos),
    .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val), .in_imm(in_imm), .in_pc(in_pc),
    .out_ready(out_ready), .out_rob_pos(out_rob_pos), .out_val(out_val),
    .out_jump(out_jump), .out_target(out_target),
    .stat_branch_cnt(stat_branch_cnt), .stat_taken_cnt(stat_taken_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic add(input logic [5:0] op, input logic [31:0] rs1, input logic [31:0] rs2,
                     input logic [31:0] imm, input logic [31:0] pc, input logic [31:0] val,
                     input logic jump, input logic [31:0] target);
    vec_t v;
    v.op = op; v.rs1 = rs1; v.rs2 = rs2; v.imm = imm; v.pc = pc;
    v.val = val; v.jump = jump; v.target = target;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic [5:0] op, input logic [31:0] rs1, input logic [31:0] rs2,
                       input logic [31:0] imm, input logic [31:0] pc, input logic [4:0] tag);
    in_enable = 1'b1; in_openum = op; in_rs1_val = rs1; in_rs2_val = rs2;
    in_imm = imm; in_pc = pc; in_rob_pos = tag;
  endtask

  task automatic check_out(input string name, input logic rdy_e, input logic [4:0] tag,
                           input logic [31:0] val, input logic jump);
    check({name, " ready"}, {31'b0, out_ready}, {31'b0, rdy_e});
    check({name, " tag"}, {27'b0, out_rob_pos}, {27'b0, tag});
    check({name, " val"}, out_val, val);
    check({name, " jump"}, {31'b0, out_jump}, {31'b0, jump});
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; clr = 1'b0; in_enable = 1'b0;
    in_openum = '0; in_rob_pos = '0; in_rs1_val = '0; in_rs2_val = '0; in_imm = '0; in_pc = '0;

    //   op        rs1           rs2           imm           pc            val           j     target
    add(OP_ADD,   32'hFFFFFFFF, 32'h00000001, 32'h0,        32'h0,        32'h00000000, 1'b0, 32'h0);
    add(OP_SRA,   32'h80000000, 32'h00000021, 32'h0,        32'h0,        32'hC0000000, 1'b0, 32'h0);
    add(OP_BLT,   32'hFFFFFFFF, 32'h00000001, 32'h20,       32'h100,      32'h0,        1'b1, 32'h120);
    add(OP_BLTU,  32'hFFFFFFFF, 32'h00000001, 32'h20,       32'h100,      32'h0,        1'b0, 32'h120);
    add(OP_JALR,  32'h00001003, 32'h0,        32'h2,        32'h40,       32'h44,       1'b1, 32'h1004);
    add(OP_SUB,   32'h5,        32'h7,        32'h0,        32'h0,        32'hFFFFFFFE, 1'b0, 32'h0);
    add(OP_SLTI,  32'hFFFFFFFF, 32'h0,        32'h0,        32'h0,        32'h1,        1'b0, 32'h0);
    add(OP_SLTIU, 32'hFFFFFFFF, 32'h0,        32'h0,        32'h0,        32'h0,        1'b0, 32'h0);
    add(OP_LUI,   32'h0,        32'h0,        32'h12345000, 32'h0,        32'h12345000, 1'b0, 32'h0);
    add(OP_AUIPC, 32'h0,        32'h0,        32'hFFFFF000, 32'h1000,     32'h0,        1'b0, 32'h0);
    add(OP_JAL,   32'h0,        32'h0,        32'hFFFFFF00, 32'h200,      32'h204,      1'b1, 32'h100);
    add(OP_BEQ,   32'h7,        32'h7,        32'h8,        32'h10,       32'h0,        1'b1, 32'h18);
    add(OP_BNE,   32'h7,        32'h7,        32'h8,        32'h10,       32'h0,        1'b0, 32'h18);
    add(OP_BGE,   32'h80000000, 32'h1,        32'h4,        32'h0,        32'h0,        1'b0, 32'h4);
    add(OP_BGEU,  32'h80000000, 32'h1,        32'h4,        32'h0,        32'h0,        1'b1, 32'h4);
    add(OP_SLLI,  32'h1,        32'h0,        32'h3F,       32'h0,        32'h80000000, 1'b0, 32'h0);
    add(OP_SRL,   32'hF0000000, 32'h4,        32'h0,        32'h0,        32'h0F000000, 1'b0, 32'h0);
    add(OP_SRAI,  32'h7FFFFFFF, 32'h0,        32'h4,        32'h0,        32'h07FFFFFF, 1'b0, 32'h0);
    add(OP_XORI,  32'hFF00FF00, 32'h0,        32'hFFFFFFFF, 32'h0,        32'h00FF00FF, 1'b0, 32'h0);
    add(OP_ORI,   32'h10,       32'h0,        32'h1,        32'h0,        32'h11,       1'b0, 32'h0);
    add(OP_AND,   32'hF0F0F0F0, 32'h0FF00FF0, 32'h0,        32'h0,        32'h00F000F0, 1'b0, 32'h0);
    add(OP_SLTU,  32'h1,        32'hFFFFFFFF, 32'h0,        32'h0,        32'h1,        1'b0, 32'h0);
    add(OP_SLT,   32'h1,        32'hFFFFFFFF, 32'h0,        32'h0,        32'h0,        1'b0, 32'h0);
    add(OP_LW,    32'h5,        32'h6,        32'h7,        32'h8,        32'h0,        1'b0, 32'h0);
    add(6'h3F,    32'h5,        32'h6,        32'h7,        32'h8,        32'h0,        1'b0, 32'h0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check_out($sformatf("idle%0d", c), 1'b0, 5'd0, 32'h0, 1'b0);
      check($sformatf("idle%0d target", c), out_target, 32'h0);
      check($sformatf("idle%0d brcnt", c), stat_branch_cnt, 32'h0);
      check($sformatf("idle%0d tkcnt", c), stat_taken_cnt, 32'h0);
    end

    // Continuous issue: one result per cycle with a fresh tag each time.
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].op, vecs[i].rs1, vecs[i].rs2, vecs[i].imm, vecs[i].pc, 5'((i % 31) + 1));
      @(negedge clk);
      check_out($sformatf("vec%0d", i), 1'b1, 5'((i % 31) + 1), vecs[i].val, vecs[i].jump);
      check($sformatf("vec%0d target", i), out_target, vecs[i].target);
    end
    in_enable = 1'b0;
    @(negedge clk);
    check("after table ready", {31'b0, out_ready}, 32'h0);
`ifdef ALU_STAT_EN
    exp_br = 32'd6; exp_tk = 32'd3;
`else
    exp_br = 32'd0; exp_tk = 32'd0;
`endif
    check("table brcnt", stat_branch_cnt, exp_br);
    check("table tkcnt", stat_taken_cnt, exp_tk);

    // Stall: tag 1 must stay on the bus while rdy is low; tag 2 is taken afterwards.
    drive(OP_ADDI, 32'd10, 32'h0, 32'd1, 32'h0, 5'd1);
    @(negedge clk);
    check_out("stall t1", 1'b1, 5'd1, 32'd11, 1'b0);
    drive(OP_ADDI, 32'd10, 32'h0, 32'd2, 32'h0, 5'd2);
    rdy = 1'b0;
    @(negedge clk);
    check_out("stall hold", 1'b1, 5'd1, 32'd11, 1'b0);
    rdy = 1'b1;
    @(negedge clk);
    check_out("stall t2", 1'b1, 5'd2, 32'd12, 1'b0);
    drive(OP_ADDI, 32'd10, 32'h0, 32'd3, 32'h0, 5'd3);
    @(negedge clk);
    check_out("stall t3", 1'b1, 5'd3, 32'd13, 1'b0);
    in_enable = 1'b0;
    @(negedge clk);
    check("stall end ready", {31'b0, out_ready}, 32'h0);

    // Three branches, two taken.
    drive(OP_BEQ, 32'h1, 32'h1, 32'h8, 32'h0, 5'd4);
    @(negedge clk);
    drive(OP_BNE, 32'h1, 32'h1, 32'h8, 32'h0, 5'd5);
    @(negedge clk);
    drive(OP_BGEU, 32'h2, 32'h1, 32'h8, 32'h0, 5'd6);
    @(negedge clk);
    check_out("br3", 1'b1, 5'd6, 32'h0, 1'b1);
`ifdef ALU_STAT_EN
    exp_br = 32'd9; exp_tk = 32'd5;
`endif
    check("br3 brcnt", stat_branch_cnt, exp_br);
    check("br3 tkcnt", stat_taken_cnt, exp_tk);

    // clr with a taken branch on the input: nothing issued, counters untouched.
    drive(OP_BEQ, 32'h3, 32'h3, 32'h8, 32'h0, 5'd7);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    in_enable = 1'b0;
    check("clr ready", {31'b0, out_ready}, 32'h0);
    check("clr jump", {31'b0, out_jump}, 32'h0);
    check("clr brcnt", stat_branch_cnt, exp_br);
    check("clr tkcnt", stat_taken_cnt, exp_tk);
    @(negedge clk);
    check("post clr ready", {31'b0, out_ready}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_unit.md
# alu_unit

- Single-issue integer execution unit directly downstream of the reservation station.
- Takes at most one ready RV32I arithmetic, logic, branch or jump operation per cycle and computes it in one cycle.
- Registers the result and broadcasts it on the common result bus to the reservation station, load/store buffer and reorder buffer.
- Also reports branch/jump resolution (taken flag and target PC) to the reorder buffer.

## Interface
Parameters:
- DATA_W, 32, operand/result/PC width
- ROB_POS_W, 5, ROB tag width; tag 0 is reserved for "no dependency" and is never issued

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rdy  in  1  global ready; when low the block holds all state and outputs
- clr  in  1  pipeline flush (mispredict); synchronous
- in_enable  in  1  operation valid this cycle; no back-pressure, always accepted
- in_openum  in  OPENUM width  decoded operation code (shared enum)
- in_rob_pos  in  ROB_POS_W  destination ROB tag
- in_rs1_val, in_rs2_val, in_imm, in_pc  in  DATA_W  operands, sign-extended immediate, instruction PC
- out_ready  out  1  result valid
- out_rob_pos  out  ROB_POS_W  tag of the result
- out_val  out  DATA_W  value to write back
- out_jump  out  1  control transfer taken
- out_target  out  DATA_W  target PC, meaningful when out_jump is 1
- stat_branch_cnt, stat_taken_cnt  out  32  statistics counters (see Configuration)

## Operation
- LUI: val = imm. AUIPC: val = pc + imm.
- JAL: val = pc + 4, jump = 1, target = pc + imm.
- JALR: val = pc + 4, jump = 1, target = (rs1 + imm) & ~1.
- BEQ/BNE/BLT/BGE/BLTU/BGEU: val = 0, target = pc + imm, jump = condition. BLT/BGE compare signed; BLTU/BGEU compare unsigned.
- Register-immediate ops (ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI) use imm as operand 2. Register-register ops (ADD, SUB, SLT, SLTU, XOR, OR, AND, SLL, SRL, SRA) use rs2.
- All arithmetic is modulo 2^DATA_W; overflow is ignored.
- Shift amount is operand2[4:0]. SRA/SRAI replicate bit 31.
- SLT/SLTI/SLTU/SLTIU produce 0 or 1.
- Non-control ops drive out_jump = 0, out_target = 0.
- An unknown openum produces val = 0, jump = 0, with out_ready still asserted so the ROB entry completes.

## Timing
- Latency 1: in_enable sampled at edge N (rdy = 1) gives out_* valid from edge N until edge N+1.
- out_ready pulses for one cycle per accepted op. With continuous input, out_ready stays high with a new tag every cycle.
- Reset: out_ready = 0, out_rob_pos = 0, out_val = 0, out_jump = 0, out_target = 0, both stat counters = 0.
- clr (takes priority over in_enable): next cycle out_ready = 0 and out_jump = 0. The input in the same cycle is discarded. Other data outputs are don't-care.
- rst wins over clr.
- rdy low: every register holds, including out_ready. Input is not consumed; the upstream producer also holds, so the op is taken at the first cycle with rdy = 1.
- clr during rdy low is ignored; the flush source must hold it.

## Configuration
- ALU_STAT_EN defined: stat_branch_cnt increments on every accepted conditional branch. stat_taken_cnt increments on every accepted conditional branch that is taken.
- Counters saturate at 0xFFFFFFFF, are cleared only by rst (not by clr), and hold when rdy is low.
- ALU_STAT_EN undefined: no counter registers; both ports are tied to 0.

## Structure
- Shared package/header: opcode enum (OPENUM width and values), DATA_W/ROB_POS_W defaults, TRUE/FALSE constants. These are shared with decoder, RS, LSB and ROB.
- Sub-module alu_calc: purely combinational compute of {val, jump, target} from openum and operands.
- alu_unit holds the output registers, clr/rdy handling and the optional counters.

## Test plan
- Reset then idle: all outputs 0 for 5 cycles; out_ready never asserts.
- ADD rs1 = 0xFFFFFFFF, rs2 = 1, tag 3 -> next cycle out_ready = 1, val = 0, rob_pos = 3. SRA rs1 = 0x80000000, rs2 = 0x21 -> val = 0xC0000000.
- BLT rs1 = 0xFFFFFFFF, rs2 = 1, pc = 0x100, imm = 0x20 -> jump = 1, target = 0x120. BLTU with the same operands -> jump = 0.
- JALR rs1 = 0x1003, imm = 2, pc = 0x40 -> val = 0x44, jump = 1, target = 0x1004.
- Back-to-back ADDI tags 1, 2, 3 with rdy low in cycle 2 -> three results, tags 1, 2, 3 in order; tag-1 output held during the stall.
- clr together with enable -> no out_ready next cycle. With ALU_STAT_EN, 3 branches of which 2 are taken -> counts 3 and 2, unchanged after clr.
